// File: rtl/fifo_dma_dat.sv
// Byte FIFO between the DMA engine (push side) and the SD DAT-line block (pop side).
// Also counts popped bytes against the block size and pulses block_done_DAT at each block end.
module fifo_dma_dat #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int BS_W   = 12
) (
   input  logic              clk_in_COM,
   input  logic              reset_in_COM,
   input  logic              flush_in_COM,
   input  logic              push_DMA,
   input  logic [DATA_W-1:0] data_in_DMA,
   input  logic              pop_DAT,
   output logic [DATA_W-1:0] data_out_DAT,
   output logic              valid_out_DAT,
   output logic              full_FIFO,
   output logic              empty_FIFO,
   output logic [ADDR_W:0]   count_FIFO,
   input  logic [BS_W-1:0]   block_size_REG,
   output logic              block_done_DAT,
   output logic              overflow_err,
   output logic              underflow_err
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [ADDR_W-1:0]            wr_ptr, rd_ptr;
   logic [ADDR_W:0]              count, count_nxt;
   logic [BS_W-1:0]              blk_cnt, blk_nxt;
   logic                         push_ok, pop_ok, blk_hit;

   // Flush blocks both strobes.
   // Push while full is only legal when a pop frees a slot in the same cycle.
   assign pop_ok  = pop_DAT  & ~empty_FIFO & ~flush_in_COM;
   assign push_ok = push_DMA & (~full_FIFO | pop_ok) & ~flush_in_COM;

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + (ADDR_W+1)'(1);
         2'b01:   count_nxt = count - (ADDR_W+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // A zero block size disables the end-of-block compare; the counter just wraps.
   assign blk_nxt = blk_cnt + BS_W'(1);
   assign blk_hit = (block_size_REG != '0) && (blk_nxt == block_size_REG);

   assign count_FIFO = count;

   always_ff @(posedge clk_in_COM) begin
      if (push_ok)
         mem[wr_ptr] <= data_in_DMA;
   end

   always_ff @(posedge clk_in_COM or negedge reset_in_COM) begin
      if (!reset_in_COM) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         blk_cnt        <= '0;
         data_out_DAT   <= '0;
         valid_out_DAT  <= 1'b0;
         block_done_DAT <= 1'b0;
         overflow_err   <= 1'b0;
         underflow_err  <= 1'b0;
         empty_FIFO     <= 1'b1;
         full_FIFO      <= 1'b0;
      end else if (flush_in_COM) begin
         // data_out_DAT deliberately keeps the last popped byte
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         blk_cnt        <= '0;
         valid_out_DAT  <= 1'b0;
         block_done_DAT <= 1'b0;
         overflow_err   <= 1'b0;
         underflow_err  <= 1'b0;
         empty_FIFO     <= 1'b1;
         full_FIFO      <= 1'b0;
      end else begin
         count          <= count_nxt;
         empty_FIFO     <= (count_nxt == '0);
         full_FIFO      <= (count_nxt == (ADDR_W+1)'(DEPTH));
         valid_out_DAT  <= pop_ok;
         block_done_DAT <= pop_ok & blk_hit;
         if (push_ok)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop_ok) begin
            data_out_DAT <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + ADDR_W'(1);
            blk_cnt      <= blk_hit ? '0 : blk_nxt;
         end
         if (push_DMA & ~push_ok)
            overflow_err <= 1'b1;
         if (pop_DAT & empty_FIFO)
            underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_dma_dat.sv
// Scoreboard bench for fifo_dma_dat: directed stimulus queues expected pop data,
// an independent monitor compares whenever valid_out_DAT is seen.
module tb_fifo_dma_dat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        push = 1'b0;
   logic [7:0]  din = '0;
   logic        pop = 1'b0;
   logic [7:0]  dout;
   logic        valid, full, empty, done, ovf, unf;
   logic [4:0]  count;
   logic [11:0] bsize = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       dn;
   } exp_t;
   exp_t expq[$];

   fifo_dma_dat dut (
      .clk_in_COM(clk), .reset_in_COM(rst_n), .flush_in_COM(flush),
      .push_DMA(push), .data_in_DMA(din), .pop_DAT(pop),
      .data_out_DAT(dout), .valid_out_DAT(valid),
      .full_FIFO(full), .empty_FIFO(empty), .count_FIFO(count),
      .block_size_REG(bsize), .block_done_DAT(done),
      .overflow_err(ovf), .underflow_err(unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs for one rising edge; returns at the following falling edge.
   task automatic step(input bit p, input logic [7:0] d, input bit q, input bit f);
      push = p; din = d; pop = q; flush = f;
      @(negedge clk);
      push = 1'b0; pop = 1'b0; flush = 1'b0;
   endtask

   task automatic expect_pop(input logic [7:0] d, input bit dn);
      exp_t e;
      e.d = d; e.dn = dn;
      expq.push_back(e);
   endtask

   // Monitor: every falling edge, compare presented output against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid: got data 0x%0h with nothing expected", dout);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("pop_data", dout, e.d);
               chk("pop_done", done, e.dn);
            end
         end else begin
            chk("done_without_valid", done, 0);
         end
      end
   end

   initial begin
      // Reset then idle
      #12;
      chk("rst_async_empty", empty, 1);
      chk("rst_async_count", count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_flags", {ovf, unf, valid, done}, 0);
      chk("rst_dout", dout, 0);

      // Fill, overflow, drain
      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      step(1, 8'hAA, 0, 0);
      chk("ovf_set", ovf, 1);
      chk("ovf_count", count, 16);
      for (int i = 0; i < 16; i++) begin
         expect_pop(8'(i), 0);
         step(0, 0, 1, 0);
      end
      chk("drain_empty", empty, 1);
      chk("drain_count", count, 0);
      chk("drain_ovf_sticky", ovf, 1);

      // Flush clears sticky error
      step(0, 0, 0, 1);
      chk("flush_ovf_clr", ovf, 0);

      // Wrap-around with concurrent push/pop
      for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + i), 0, 0);
      for (int i = 0; i < 10; i++) begin
         expect_pop(8'(8'h20 + i), 0);
         step(0, 0, 1, 0);
      end
      step(1, 8'h30, 0, 0);
      for (int i = 1; i < 12; i++) begin
         expect_pop(8'(8'h30 + i - 1), 0);
         step(1, 8'(8'h30 + i), 1, 0);
         chk("wrap_count", count, 1);
      end
      expect_pop(8'h3B, 0);
      step(0, 0, 1, 0);
      chk("wrap_empty", empty, 1);
      chk("wrap_no_unf", unf, 0);

      // Empty with simultaneous push/pop
      step(1, 8'h77, 1, 0);
      chk("empty_pp_count", count, 1);
      chk("empty_pp_unf", unf, 1);
      chk("empty_pp_valid", valid, 0);
      expect_pop(8'h77, 0);
      step(0, 0, 1, 0);

      // Full with simultaneous push/pop
      for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
      expect_pop(8'h40, 0);
      step(1, 8'h50, 1, 0);
      chk("full_pp_count", count, 16);
      chk("full_pp_full", full, 1);
      chk("full_pp_no_ovf", ovf, 0);
      step(1, 8'hAA, 0, 0);
      chk("full_ovf", ovf, 1);

      // Leave 5 stored, both errors set, then flush together with a push
      for (int i = 1; i < 12; i++) begin
         expect_pop(8'(8'h40 + i), 0);
         step(0, 0, 1, 0);
      end
      chk("pre_flush_count", count, 5);
      step(1, 8'hEE, 0, 1);
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_errs", {ovf, unf}, 0);
      chk("flush_dout_kept", dout, 8'h4B);
      chk("flush_valid", valid, 0);
      step(1, 8'h99, 0, 0);
      chk("post_flush_count", count, 1);
      expect_pop(8'h99, 0);
      step(0, 0, 1, 0);

      // Block accounting: size 3, pulse on 3rd and 6th pops (counter was 1, flush clears it)
      step(0, 0, 0, 1);
      bsize = 12'd3;
      for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + i), 0, 0);
      for (int i = 0; i < 7; i++) begin
         expect_pop(8'(8'h60 + i), (i == 2 || i == 5));
         step(0, 0, 1, 0);
      end
      bsize = 12'd0;
      for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0, 0);
      for (int i = 0; i < 4; i++) begin
         expect_pop(8'(8'h70 + i), 0);
         step(0, 0, 1, 0);
      end

      // Asynchronous reset between edges
      step(1, 8'h5A, 0, 0);
      step(1, 8'h5B, 0, 0);
      expect_pop(8'h5A, 0);
      step(0, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_count", count, 0);
      chk("areset_empty", empty, 1);
      chk("areset_dout", dout, 0);
      chk("areset_valid", valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0);
      chk("post_reset_empty", empty, 1);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
